// File: rtl/pkt_pkg.sv
// Packet format constants shared by the upstream byte-stream parser and the packet FIFO.
// A packet is three bytes, first byte in the most significant position.
package pkt_pkg;

    localparam int PKT_W        = 24;
    localparam int BYTE_W       = 8;
    localparam int HDR_FLAG_BIT = 3;

    // Position of the header flag within a whole packet (bit 3 of the first byte).
    localparam int PKT_HDR_BIT  = PKT_W - BYTE_W + HDR_FLAG_BIT;

endpackage : pkt_pkg

// File: rtl/packet_fifo.sv
// Packet FIFO between the byte-stream parser and a ready/valid consumer.
// Drops packets on overflow with a saturating counter and flags frames whose header bit is clear.
module packet_fifo
    import pkt_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     pkt_done,
    input  logic [PKT_W-1:0]         pkt_bytes,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PKT_W-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     frame_err
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [PKT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    // Level is the single source of truth for full/empty, so wrapped pointers are never ambiguous.
    assign full      = (level == LVL_W'(DEPTH));
    assign out_valid = (level != '0);
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid && out_ready;
    assign push      = pkt_done && (!full || pop);
    assign drop      = pkt_done && full && !pop;

    // NOTE: the storage array has no reset; stale entries are unreachable once level is cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= pkt_bytes;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            drop_cnt  <= '0;
            frame_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level + LVL_W'(push) - LVL_W'(pop);
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
            // A malformed header is flagged even if the packet itself is dropped.
            if (pkt_done && !pkt_bytes[PKT_HDR_BIT]) begin
                frame_err <= 1'b1;
            end
        end
    end

endmodule : packet_fifo

// File: tb/tb_packet_fifo.sv
// Self-checking bench for packet_fifo against a queue-based reference model.
// Each scenario task drives stimulus and compares DUT outputs with the model inline.
module tb_packet_fifo;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              clk;
    logic              reset_n;
    logic              pkt_done;
    logic [23:0]       pkt_bytes;
    logic              out_valid;
    logic              out_ready;
    logic [23:0]       out_data;
    logic [LVL_W-1:0]  level;
    logic [CNT_W-1:0]  drop_cnt;
    logic              frame_err;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: a bounded queue plus drop counter and sticky error bit.
    logic [23:0] mq[$];
    int          m_drops;
    logic        m_ferr;

    logic [23:0] dut_pops[$];
    logic [23:0] model_pops[$];

    packet_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pkt_done  (pkt_done),
        .pkt_bytes (pkt_bytes),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .drop_cnt  (drop_cnt),
        .frame_err (frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock cycle: drive inputs, record what the DUT hands out, advance the model.
    task automatic step(input logic done, input logic [23:0] bytes, input logic ready);
        pkt_done  = done;
        pkt_bytes = bytes;
        out_ready = ready;
        @(negedge clk);
        if (out_valid && ready) dut_pops.push_back(out_data);
        @(posedge clk);
        if (mq.size() > 0 && ready) model_pops.push_back(mq.pop_front());
        if (done) begin
            if (mq.size() < DEPTH) mq.push_back(bytes);
            else if (m_drops < (1 << CNT_W) - 1) m_drops++;
            if (!bytes[19]) m_ferr = 1'b1;
        end
        #1;
        pkt_done = 1'b0;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        pkt_done  = 1'b1;
        out_ready = 1'b1;
        pkt_bytes = 24'h000000;
        @(posedge clk);
        mq.delete();
        m_drops = 0;
        m_ferr  = 1'b0;
        #1;
        reset_n  = 1'b1;
        pkt_done = 1'b0;
        dut_pops.delete();
        model_pops.delete();
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && mq.size() > 0; i++) step(1'b0, 24'h0, 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (out_valid !== 1'b0 || level !== '0 || drop_cnt !== '0 || frame_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: valid=%b level=%0d drop=%0d ferr=%b, want 0/0/0/0",
                     out_valid, level, drop_cnt, frame_err);
        end
    endtask

    task automatic test_single();
        do_reset();
        step(1'b1, 24'h8A1234, 1'b0);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 24'h8A1234 || level !== LVL_W'(1)) begin
            tests_failed++;
            $display("FAIL single_latency: valid=%b data=%h level=%0d, want 1/8a1234/1",
                     out_valid, out_data, level);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 24'h0, 1'b0);
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== 24'h8A1234 || level !== LVL_W'(1)) begin
                tests_failed++;
                $display("FAIL single_hold[%0d]: valid=%b data=%h level=%0d, want 1/8a1234/1",
                         i, out_valid, out_data, level);
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 6; i++) step(1'b1, 24'h080000 + 24'(i), 1'b0);
        tests_run++;
        if (level !== LVL_W'(4) || drop_cnt !== CNT_W'(2)) begin
            tests_failed++;
            $display("FAIL overflow_fill: level=%0d drop=%0d, want 4/2", level, drop_cnt);
        end
        drain(10);
        tests_run++;
        if (dut_pops.size() != 4) begin
            tests_failed++;
            $display("FAIL overflow_drain_count: got %0d pops, want 4", dut_pops.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (dut_pops[i] !== 24'h080001 + 24'(i)) begin
                    tests_failed++;
                    $display("FAIL overflow_order[%0d]: got %h, want %h", i, dut_pops[i],
                             24'h080001 + 24'(i));
                end
            end
        end
        tests_run++;
        if (level !== '0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL overflow_empty: level=%0d valid=%b, want 0/0", level, out_valid);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 24'h0A0010 + 24'(i), 1'b0);
        step(1'b1, 24'h0ABCDE, 1'b1);
        tests_run++;
        if (level !== LVL_W'(4) || drop_cnt !== '0 || out_data !== 24'h0A0011) begin
            tests_failed++;
            $display("FAIL full_push_pop: level=%0d drop=%0d head=%h, want 4/0/0a0011",
                     level, drop_cnt, out_data);
        end
        drain(10);
        tests_run++;
        if (dut_pops.size() != 5 || dut_pops[dut_pops.size()-1] !== 24'h0ABCDE) begin
            tests_failed++;
            $display("FAIL full_push_pop_last: pops=%0d last=%h, want 5/0abcde", dut_pops.size(),
                     dut_pops.size() > 0 ? dut_pops[dut_pops.size()-1] : 24'hx);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 304; i++) step(1'b1, 24'h080000 | 24'($urandom), 1'b0);
        tests_run++;
        if (drop_cnt !== 8'd255 || level !== LVL_W'(4)) begin
            tests_failed++;
            $display("FAIL drop_saturate: drop=%0d level=%0d, want 255/4", drop_cnt, level);
        end
    endtask

    task automatic test_frame_err();
        do_reset();
        step(1'b1, 24'h001122, 1'b0);
        tests_run++;
        if (frame_err !== 1'b1 || level !== LVL_W'(1) || out_data !== 24'h001122) begin
            tests_failed++;
            $display("FAIL frame_err_set: ferr=%b level=%0d data=%h, want 1/1/001122",
                     frame_err, level, out_data);
        end
        step(1'b1, 24'h0F0000, 1'b1);
        tests_run++;
        if (frame_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL frame_err_sticky: ferr=%b, want 1", frame_err);
        end
        do_reset();
        tests_run++;
        if (frame_err !== 1'b0 || level !== '0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL frame_err_reset: ferr=%b level=%0d valid=%b, want 0/0/0",
                     frame_err, level, out_valid);
        end
    endtask

    task automatic test_stream();
        logic [23:0] sent[$];
        int          max_level = 0;
        do_reset();
        for (int p = 0; p < 1000; p++) begin
            logic [23:0] d;
            d = 24'($urandom) | 24'h080000;
            sent.push_back(d);
            step(1'b1, d, 1'b1);
            if (int'(level) > max_level) max_level = int'(level);
            for (int k = 0; k < 2; k++) begin
                step(1'b0, 24'h0, 1'b1);
                if (int'(level) > max_level) max_level = int'(level);
            end
        end
        tests_run++;
        if (drop_cnt !== '0 || max_level > 1) begin
            tests_failed++;
            $display("FAIL stream_level: drop=%0d max_level=%0d, want 0/<=1", drop_cnt, max_level);
        end
        tests_run++;
        if (dut_pops != sent) begin
            tests_failed++;
            $display("FAIL stream_order: got %0d pops, first=%h, want %0d pops, first=%h",
                     dut_pops.size(), dut_pops.size() > 0 ? dut_pops[0] : 24'hx,
                     sent.size(), sent[0]);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [23:0] d;
            d = 24'($urandom);
            if ($urandom_range(9) != 0) d[19] = 1'b1;
            if ($urandom_range(499) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(2) != 0), d, 1'($urandom_range(3) == 0));
            end
            tests_run++;
            if (level !== LVL_W'(mq.size()) || out_valid !== (mq.size() > 0) ||
                (mq.size() > 0 && out_data !== mq[0]) || drop_cnt !== CNT_W'(m_drops) ||
                frame_err !== m_ferr) begin
                tests_failed++;
                if (bad < 10)
                    $display("FAIL random[%0d]: level=%0d valid=%b data=%h drop=%0d ferr=%b, want %0d/%b/%h/%0d/%b",
                             c, level, out_valid, out_data, drop_cnt, frame_err, mq.size(),
                             mq.size() > 0, mq.size() > 0 ? mq[0] : 24'hx, m_drops, m_ferr);
                bad++;
            end
        end
        tests_run++;
        if (dut_pops != model_pops) begin
            tests_failed++;
            $display("FAIL random_pops: got %0d pops, want %0d", dut_pops.size(), model_pops.size());
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        pkt_done  = 1'b0;
        pkt_bytes = 24'h0;
        out_ready = 1'b0;
        m_drops   = 0;
        m_ferr    = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_saturate();
        test_frame_err();
        test_stream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_packet_fifo

// File: doc/packet_fifo.md
PACKET_FIFO -- requirements
Module: packet_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of 24-bit packet entries; power of two, minimum 2.
REQ-002 SHALL have parameter CNT_W, default 8, width of the drop counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset; one clock, reset is synchronous and active-low.
REQ-005 SHALL have port pkt_done  input  1  one-cycle strobe from the upstream byte-stream packet parser; packet complete.
REQ-006 SHALL have port pkt_bytes  input  24  packet contents: [23:16] first byte, [15:8] second, [7:0] third; sampled only when pkt_done=1.
REQ-007 SHALL have port out_valid  output  1  FIFO non-empty; head packet presented.
REQ-008 SHALL have port out_ready  input  1  consumer accepts head when out_valid=1.
REQ-009 SHALL have port out_data  output  24  head packet, same byte order as pkt_bytes.
REQ-010 SHALL have port level  output  clog2(DEPTH)+1  current number of stored packets.
REQ-011 SHALL have port drop_cnt  output  CNT_W  saturating count of packets dropped on overflow.
REQ-012 SHALL have port frame_err  output  1  sticky flag; a pkt_done was seen with pkt_bytes[19]=0 (first byte lacks bit 3).

Function
REQ-013 SHALL write pkt_bytes into the tail entry on any clk edge with pkt_done=1 and the FIFO not full, or full with a pop in the same cycle.
REQ-014 SHALL define pop as out_valid=1 and out_ready=1 on a clk edge; pop removes the head entry.
REQ-015 SHALL drive out_valid=1 exactly when level>0; no write-to-read bypass.
REQ-016 SHALL give one-cycle latency: pkt_done at edge N into an empty FIFO yields out_valid=1 after edge N, with out_data=that packet.
REQ-017 SHALL hold out_data stable while out_valid=1 and out_ready=0; out_data is don't-care while out_valid=0.
REQ-018 SHALL keep level unchanged on simultaneous accepted write and pop, including when full and when level=1.
REQ-019 SHALL, when full with no pop, discard the incoming packet, leave contents unchanged, and increment drop_cnt.
REQ-020 SHALL saturate drop_cnt at 2^CNT_W-1; no wrap.
REQ-021 SHALL ignore out_ready while out_valid=0; level never underflows.
REQ-022 SHALL wrap read and write pointers modulo DEPTH; full/empty derived from an extra pointer MSB or from level, never ambiguous.
REQ-023 SHALL still store a packet with pkt_bytes[19]=0 (subject to space) and set frame_err, which stays 1 until reset.
REQ-024 SHALL preserve packet order; first written is first popped.

Reset
REQ-025 SHALL, on a clk edge with reset_n=0, set pointers to 0, level=0, out_valid=0, drop_cnt=0, frame_err=0; pkt_done and out_ready ignored that cycle.
REQ-026 SHALL discard all stored packets on reset mid-operation; first packet after reset_n rises takes effect normally.
REQ-027 SHALL not require reset of the storage array.

Structure
REQ-028 SHALL take PKT_W=24, BYTE_W=8 and the header flag bit position (3) from shared package pkt_pkg, also used by the upstream parser.
REQ-029 SHALL be a single module; no sub-module, storage inferred as a register array.

Verification
REQ-030 SHALL cover: reset, pkt_done with 0x8A1234, out_ready=0 -> next cycle out_valid=1, out_data=0x8A1234, level=1, held for 5 cycles.
REQ-031 SHALL cover: 6 packets 0x080001..0x080006 back-to-back, out_ready=0, DEPTH=4 -> level=4, drop_cnt=2, then draining pops 0x080001..0x080004 in order.
REQ-032 SHALL cover: full FIFO, pkt_done and pop same cycle -> level stays 4, drop_cnt unchanged, new packet popped last.
REQ-033 SHALL cover: 300 overflow packets with CNT_W=8 -> drop_cnt=255.
REQ-034 SHALL cover: pkt_done with 0x001122 -> frame_err=1 and packet stored; reset_n=0 one cycle -> frame_err=0, level=0, out_valid=0.
REQ-035 SHALL cover: continuous pkt_done every 3 cycles with out_ready=1 for 1000 packets -> drop_cnt=0, level<=1, output sequence equals input.
